// File: rtl/cdb_result_stage.sv
// Per-source result FIFOs feeding the CDB: requests to the arbiter, pops on its grant,
// registered broadcast. Optional grant checker enabled by defining CDB_GRANT_CHECK_EN.
module cdb_result_stage #(
  parameter int NSRC  = 3,
  parameter int TAGW  = 6,
  parameter int DATAW = 32,
  parameter int DEPTH = 2,
  localparam int SRCW = (NSRC > 1) ? $clog2(NSRC) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_flush,
  input  logic [NSRC-1:0]       i_fu_valid,
  output logic [NSRC-1:0]       o_fu_ready,
  input  logic [NSRC*TAGW-1:0]  i_fu_tag,
  input  logic [NSRC*DATAW-1:0] i_fu_data,
  output logic [NSRC-1:0]       o_req,
  input  logic [NSRC-1:0]       i_grant,
  output logic                  o_cdb_valid,
  output logic [TAGW-1:0]       o_cdb_tag,
  output logic [DATAW-1:0]      o_cdb_data,
  output logic [SRCW-1:0]       o_cdb_src
`ifdef CDB_GRANT_CHECK_EN
  ,
  output logic                  o_grant_err
`endif
);

  localparam int PTRW = $clog2(DEPTH);
  localparam int CNTW = PTRW + 1;
  localparam logic [CNTW-1:0] FULL = CNTW'(DEPTH);
  localparam logic [CNTW-1:0] ONE  = CNTW'(1);

  logic [TAGW-1:0]  tag_mem  [NSRC][DEPTH];
  logic [DATAW-1:0] data_mem [NSRC][DEPTH];
  logic [PTRW-1:0]  wr_ptr   [NSRC];
  logic [PTRW-1:0]  rd_ptr   [NSRC];
  logic [CNTW-1:0]  cnt      [NSRC];

  logic [NSRC-1:0]  nonempty;
  logic [NSRC-1:0]  push;
  logic [NSRC-1:0]  pop;
  logic [SRCW-1:0]  pop_idx;
  logic [TAGW-1:0]  head_tag;
  logic [DATAW-1:0] head_data;

  for (genvar g = 0; g < NSRC; g++) begin : g_status
    assign nonempty[g]   = (cnt[g] != '0);
    assign o_fu_ready[g] = (cnt[g] < FULL);
    assign push[g]       = i_fu_valid[g] & o_fu_ready[g];
    // Grant lags request by a cycle: a lone entry being popped must not re-request.
    assign o_req[g]      = (cnt[g] > ONE) | ((cnt[g] == ONE) & ~i_grant[g]);
  end

  // Descending scan so the lowest-index granted non-empty source wins a multi-hot grant.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    pop       = '0;
    pop_idx   = '0;
    head_tag  = '0;
    head_data = '0;
    for (int i = NSRC - 1; i >= 0; i--) begin
      if (i_grant[i] && nonempty[i]) begin
        pop       = '0;
        pop[i]    = 1'b1;
        pop_idx   = SRCW'(i);
        head_tag  = tag_mem[i][rd_ptr[i]];
        head_data = data_mem[i][rd_ptr[i]];
      end
    end
  end

  // NOTE: FIFO storage is deliberately not reset; cnt alone decides which entries are live.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NSRC; i++) begin
      if (push[i]) begin
        tag_mem[i][wr_ptr[i]]  <= i_fu_tag[i*TAGW +: TAGW];
        data_mem[i][wr_ptr[i]] <= i_fu_data[i*DATAW +: DATAW];
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NSRC; i++) begin
        cnt[i]    <= '0;
        wr_ptr[i] <= '0;
        rd_ptr[i] <= '0;
      end
      o_cdb_valid <= 1'b0;
      o_cdb_tag   <= '0;
      o_cdb_data  <= '0;
      o_cdb_src   <= '0;
    end else if (i_flush) begin
      for (int i = 0; i < NSRC; i++) begin
        cnt[i]    <= '0;
        wr_ptr[i] <= '0;
        rd_ptr[i] <= '0;
      end
      o_cdb_valid <= 1'b0;
    end else begin
      for (int i = 0; i < NSRC; i++) begin
        if (push[i]) wr_ptr[i] <= wr_ptr[i] + PTRW'(1);
        if (pop[i])  rd_ptr[i] <= rd_ptr[i] + PTRW'(1);
        if (push[i] && !pop[i])      cnt[i] <= cnt[i] + ONE;
        else if (pop[i] && !push[i]) cnt[i] <= cnt[i] - ONE;
      end
      o_cdb_valid <= |pop;
      if (|pop) begin
        o_cdb_tag  <= head_tag;
        o_cdb_data <= head_data;
        o_cdb_src  <= pop_idx;
      end
    end
  end

`ifdef CDB_GRANT_CHECK_EN
  logic grant_bad;

  assign grant_bad = ((i_grant != '0) && !$onehot(i_grant)) || (|(i_grant & ~nonempty));

  always_ff @(posedge clk) begin
    if (rst) o_grant_err <= 1'b0;
    else     o_grant_err <= grant_bad;
  end

  a_grant_onehot0: assert property (@(posedge clk) disable iff (rst) $onehot0(i_grant));
  a_push_only_when_ready: assert property (@(posedge clk) disable iff (rst)
    ((push & ~o_fu_ready) == '0));
`endif

endmodule

// File: tb/tb_cdb_result_stage.sv
// Directed bench for cdb_result_stage; the bench plays the FUs and a registered arbiter.
`timescale 1ns/1ps
module tb_cdb_result_stage;

  logic        clk;
  logic        rst;
  logic        i_flush;
  logic [2:0]  i_fu_valid;
  logic [2:0]  o_fu_ready;
  logic [17:0] i_fu_tag;
  logic [95:0] i_fu_data;
  logic [2:0]  o_req;
  logic [2:0]  i_grant;
  logic        o_cdb_valid;
  logic [5:0]  o_cdb_tag;
  logic [31:0] o_cdb_data;
  logic [1:0]  o_cdb_src;
`ifdef CDB_GRANT_CHECK_EN
  logic        o_grant_err;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  cdb_result_stage dut (
    .clk        (clk),
    .rst        (rst),
    .i_flush    (i_flush),
    .i_fu_valid (i_fu_valid),
    .o_fu_ready (o_fu_ready),
    .i_fu_tag   (i_fu_tag),
    .i_fu_data  (i_fu_data),
    .o_req      (o_req),
    .i_grant    (i_grant),
    .o_cdb_valid(o_cdb_valid),
    .o_cdb_tag  (o_cdb_tag),
    .o_cdb_data (o_cdb_data),
    .o_cdb_src  (o_cdb_src)
`ifdef CDB_GRANT_CHECK_EN
    ,
    .o_grant_err(o_grant_err)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", name, obs, exp);
    end
  endtask

  task automatic check_cdb(input string name, input logic [5:0] tag, input logic [31:0] data,
                           input logic [1:0] src);
    check({name, ".valid"}, o_cdb_valid, 1'b1);
    check({name, ".tag"},   o_cdb_tag,   tag);
    check({name, ".data"},  o_cdb_data,  data);
    check({name, ".src"},   o_cdb_src,   src);
  endtask

  task automatic check_err(input string name, input logic exp);
`ifdef CDB_GRANT_CHECK_EN
    check(name, o_grant_err, exp);
`endif
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic set_fu(input int src, input logic [5:0] tag, input logic [31:0] data);
    i_fu_tag[src*6 +: 6]   = tag;
    i_fu_data[src*32 +: 32] = data;
  endtask

  initial begin
    rst        = 1'b1;
    i_flush    = 1'b0;
    i_fu_valid = '0;
    i_grant    = '0;
    i_fu_tag   = '0;
    i_fu_data  = '0;
    tick();
    tick();
    check("rst.cdb_valid", o_cdb_valid, 1'b0);
    check("rst.cdb_tag",   o_cdb_tag,   6'd0);
    check("rst.cdb_data",  o_cdb_data,  32'd0);
    check("rst.cdb_src",   o_cdb_src,   2'd0);
    check("rst.req",       o_req,       3'b000);
    check("rst.ready",     o_fu_ready,  3'b111);
    check_err("rst.err", 1'b0);
    rst = 1'b0;

    // T1: single result through the full push -> req -> grant -> CDB path
    i_fu_valid = 3'b010;
    set_fu(1, 6'd5, 32'h0000_DEAD);
    tick();
    i_fu_valid = '0;
    check("t1.req_after_push", o_req, 3'b010);
    tick();
    check("t1.req_held", o_req, 3'b010);
    i_grant = 3'b010;
    settle();
    check("t1.req_masked", o_req, 3'b000);
    tick();
    i_grant = '0;
    check_cdb("t1.cdb", 6'd5, 32'h0000_DEAD, 2'd1);
    check("t1.req_after_pop", o_req, 3'b000);
    tick();
    check("t1.cdb_drop", o_cdb_valid, 1'b0);
    check("t1.tag_hold", o_cdb_tag, 6'd5);

    // T2: FU0 fills its FIFO, third result held until a pop frees space
    i_fu_valid = 3'b001;
    set_fu(0, 6'd1, 32'hA1);
    tick();
    check("t2.ready_one", o_fu_ready, 3'b111);
    set_fu(0, 6'd2, 32'hA2);
    tick();
    check("t2.ready_full", o_fu_ready, 3'b110);
    check("t2.req_full", o_req, 3'b001);
    set_fu(0, 6'd3, 32'hA3);
    tick();
    check("t2.ready_still_full", o_fu_ready, 3'b110);
    i_grant = 3'b001;
    settle();
    check("t2.req_two_granted", o_req, 3'b001);
    check("t2.no_bypass", o_fu_ready, 3'b110);
    tick();
    i_grant = '0;
    check_cdb("t2.cdb_a1", 6'd1, 32'hA1, 2'd0);
    check("t2.ready_back", o_fu_ready, 3'b111);
    tick();
    i_fu_valid = '0;
    check("t2.idle_valid", o_cdb_valid, 1'b0);
    check("t2.third_taken", o_fu_ready, 3'b110);
    i_grant = 3'b001;
    tick();
    check_cdb("t2.cdb_a2", 6'd2, 32'hA2, 2'd0);
    tick();
    check_cdb("t2.cdb_a3", 6'd3, 32'hA3, 2'd0);
    check("t2.ready_empty", o_fu_ready, 3'b111);
    check("t2.req_empty", o_req, 3'b000);
    i_grant = '0;
    tick();
    check("t2.cdb_drop", o_cdb_valid, 1'b0);

    // T3: a lone entry under grant is not re-requested; a stale re-grant broadcasts nothing
    i_fu_valid = 3'b100;
    set_fu(2, 6'd9, 32'hC9);
    tick();
    i_fu_valid = '0;
    check("t3.req", o_req, 3'b100);
    tick();
    i_grant = 3'b100;
    settle();
    check("t3.req_masked", o_req, 3'b000);
    tick();
    check_cdb("t3.cdb", 6'd9, 32'hC9, 2'd2);
    check_err("t3.err_clean", 1'b0);
    tick();
    check("t3.stale_valid", o_cdb_valid, 1'b0);
    check("t3.stale_tag_hold", o_cdb_tag, 6'd9);
    check_err("t3.err_stale", 1'b1);
    i_grant = '0;
    tick();
    check_err("t3.err_clear", 1'b0);

    // T4: three sources pending, served one per cycle in grant order 0,1,2
    i_fu_valid = 3'b111;
    set_fu(0, 6'd10, 32'hB0);
    set_fu(1, 6'd11, 32'hB1);
    set_fu(2, 6'd12, 32'hB2);
    tick();
    i_fu_valid = '0;
    check("t4.req_all", o_req, 3'b111);
    tick();
    i_grant = 3'b001;
    settle();
    check("t4.req_g0", o_req, 3'b110);
    tick();
    check_cdb("t4.cdb0", 6'd10, 32'hB0, 2'd0);
    i_grant = 3'b010;
    settle();
    check("t4.req_g1", o_req, 3'b100);
    tick();
    check_cdb("t4.cdb1", 6'd11, 32'hB1, 2'd1);
    i_grant = 3'b100;
    settle();
    check("t4.req_g2", o_req, 3'b000);
    tick();
    check_cdb("t4.cdb2", 6'd12, 32'hB2, 2'd2);
    i_grant = '0;
    tick();
    check("t4.cdb_drop", o_cdb_valid, 1'b0);
    check("t4.req_none", o_req, 3'b000);

    // T5: flush beats a same-cycle push and grant
    i_fu_valid = 3'b010;
    set_fu(1, 6'd20, 32'hD0);
    tick();
    i_fu_valid = '0;
    tick();
    i_fu_valid = 3'b011;
    set_fu(0, 6'd21, 32'hD1);
    set_fu(1, 6'd22, 32'hD2);
    i_grant = 3'b010;
    i_flush = 1'b1;
    tick();
    i_flush    = 1'b0;
    i_fu_valid = '0;
    i_grant    = '0;
    check("t5.cdb_valid", o_cdb_valid, 1'b0);
    check("t5.tag_hold", o_cdb_tag, 6'd12);
    check("t5.req", o_req, 3'b000);
    check("t5.ready", o_fu_ready, 3'b111);
    i_grant = 3'b011;
    tick();
    i_grant = '0;
    check("t5.no_broadcast", o_cdb_valid, 1'b0);
    check("t5.req_after", o_req, 3'b000);

    // T6: multi-hot grant pops only the lowest-index non-empty source
    i_fu_valid = 3'b011;
    set_fu(0, 6'd30, 32'hE0);
    set_fu(1, 6'd31, 32'hE1);
    tick();
    i_fu_valid = '0;
    check("t6.req", o_req, 3'b011);
    tick();
    i_grant = 3'b011;
    tick();
    i_grant = '0;
    check_cdb("t6.cdb0", 6'd30, 32'hE0, 2'd0);
    check_err("t6.err_multihot", 1'b1);
    settle();
    check("t6.src1_kept", o_req, 3'b010);
    tick();
    check("t6.cdb_drop", o_cdb_valid, 1'b0);
    i_grant = 3'b010;
    tick();
    i_grant = '0;
    check_cdb("t6.cdb1", 6'd31, 32'hE1, 2'd1);
    tick();
    check("t6.req_final", o_req, 3'b000);

    // Reset mid-operation clears the CDB registers too
    i_fu_valid = 3'b001;
    set_fu(0, 6'd40, 32'hF0);
    tick();
    i_fu_valid = '0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst2.req", o_req, 3'b000);
    check("rst2.tag", o_cdb_tag, 6'd0);
    check("rst2.data", o_cdb_data, 32'd0);
    check("rst2.src", o_cdb_src, 2'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
